// File: rtl/n64_button_event_queue_if.sv
// Bus between the N64 button event queue and its host: sample input, FIFO pop side
// and the filtered-state outputs.
interface n64_button_event_queue_if #(
    parameter int unsigned DEPTH = 16
);
    logic                     enable;
    logic                     sample_valid;
    logic [31:0]              button_data;
    logic                     pop;
    logic                     clear_overflow;
    logic [31:0]              event_data;
    logic                     event_valid;
    logic [$clog2(DEPTH):0]   event_count;
    logic                     overflow;
    logic [15:0]              buttons;
    logic [7:0]               stick_x;
    logic [7:0]               stick_y;

    modport master (
        output enable, sample_valid, button_data, pop, clear_overflow,
        input  event_data, event_valid, event_count, overflow, buttons, stick_x, stick_y
    );

    modport slave (
        input  enable, sample_valid, button_data, pop, clear_overflow,
        output event_data, event_valid, event_count, overflow, buttons, stick_x, stick_y
    );
endinterface

// File: rtl/n64_button_event_queue.sv
// Debounces N64 controller buttons, deadzones the stick axes and queues button-change
// events in a first-word fall-through FIFO for software to pop.
module n64_button_event_queue #(
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned STABLE_SAMPLES = 3,
    parameter int unsigned DEADZONE       = 8
) (
    input logic                     PCLK,
    input logic                     PRESERN,
    n64_button_event_queue_if.slave bus
);
    localparam int unsigned     AW         = $clog2(DEPTH);
    localparam int unsigned     RW         = $clog2(STABLE_SAMPLES + 1);
    localparam logic [RW-1:0]   RUN_MAX    = RW'(STABLE_SAMPLES);
    localparam logic [AW:0]     FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [8:0]      DZ         = 9'(DEADZONE);

    logic            accept;
    logic [15:0]     s;
    logic [15:0]     cand;
    logic [15:0]     buttons;
    logic [RW-1:0]   run;
    logic [RW-1:0]   new_run;
    logic            push_event;
    logic [31:0]     push_data;

    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            empty;
    logic            full;
    logic            do_pop;
    logic            do_push;
    logic            drop;
    logic            overflow;

    logic [7:0]      stick_x;
    logic [7:0]      stick_y;

    // Magnitude is taken in 9 bits so that -128 maps to 128 instead of wrapping.
    function automatic logic [7:0] deadzone(input logic [7:0] v);
        logic [8:0] mag;
        mag = v[7] ? (9'd0 - {v[7], v}) : {1'b0, v};
        return (mag <= DZ) ? 8'h00 : v;
    endfunction

    assign accept = bus.enable && bus.sample_valid;
    assign s      = bus.button_data[31:16];

    always_comb begin
        new_run = '0;
        if (s != cand) begin
            new_run = RW'(1);
        end else if (run >= RUN_MAX) begin
            new_run = RUN_MAX;
        end else begin
            new_run = run + 1'b1;
        end
    end

    assign push_event = accept && (new_run >= RUN_MAX) && (s != buttons);
    assign push_data  = {s, s ^ buttons};

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            cand    <= '0;
            run     <= '0;
            buttons <= '0;
            stick_x <= '0;
            stick_y <= '0;
        end else if (accept) begin
            cand    <= s;
            run     <= new_run;
            stick_x <= deadzone(bus.button_data[15:8]);
            stick_y <= deadzone(bus.button_data[7:0]);
            if (push_event) begin
                buttons <= s;
            end
        end
    end

    // A pop on an empty FIFO is ignored, so a full FIFO only accepts a push when it really pops.
    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = bus.pop && !empty;
    assign do_push = push_event && (!full || do_pop);
    assign drop    = push_event && full && !do_pop;

    always_ff @(posedge PCLK) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (bus.clear_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    assign bus.event_data  = empty ? '0 : mem[rd_ptr];
    assign bus.event_valid = !empty;
    assign bus.event_count = count;
    assign bus.overflow    = overflow;
    assign bus.buttons     = buttons;
    assign bus.stick_x     = stick_x;
    assign bus.stick_y     = stick_y;
endmodule

// File: tb/tb_n64_button_event_queue.sv
// Directed bench for n64_button_event_queue: expected events go into a scoreboard
// queue and a monitor compares the FIFO head whenever it is popped.
module tb_n64_button_event_queue;
    localparam int unsigned DEPTH = 4;

    logic PCLK = 1'b0;
    logic PRESERN;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_q[$];

    n64_button_event_queue_if #(.DEPTH(DEPTH)) bus ();

    n64_button_event_queue #(
        .DEPTH(DEPTH),
        .STABLE_SAMPLES(3),
        .DEADZONE(8)
    ) dut (
        .PCLK(PCLK),
        .PRESERN(PRESERN),
        .bus(bus)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: the head being popped must be the oldest expected event.
    always @(negedge PCLK) begin
        if (PRESERN && bus.pop && bus.event_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got 0x%08h, expected no event", bus.event_data);
            end else begin
                check("pop_head", bus.event_data, exp_q.pop_front());
            end
        end
    end

    task automatic cycle(input logic en, input logic sv, input logic [31:0] d,
                         input logic p, input logic co);
        bus.enable         = en;
        bus.sample_valid   = sv;
        bus.button_data    = d;
        bus.pop            = p;
        bus.clear_overflow = co;
        @(posedge PCLK);
        #1;
        bus.enable         = 1'b1;
        bus.sample_valid   = 1'b0;
        bus.pop            = 1'b0;
        bus.clear_overflow = 1'b0;
    endtask

    task automatic smp(input logic [31:0] d);
        cycle(1'b1, 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic smp3_event(input logic [31:0] d, input logic [31:0] evt);
        smp(d);
        smp(d);
        exp_q.push_back(evt);
        smp(d);
    endtask

    task automatic pop_one();
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic check_count(input string name, input int unsigned n);
        check(name, 32'(bus.event_count), 32'(n));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bus.enable         = 1'b1;
        bus.sample_valid   = 1'b0;
        bus.button_data    = 32'h0;
        bus.pop            = 1'b0;
        bus.clear_overflow = 1'b0;
        PRESERN            = 1'b0;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        PRESERN = 1'b1;
        @(posedge PCLK);
        #1;

        check("reset_valid", 32'(bus.event_valid), 32'h0);
        check_count("reset_count", 0);
        check("reset_buttons", 32'(bus.buttons), 32'h0);
        check("reset_overflow", 32'(bus.overflow), 32'h0);
        check("reset_data", bus.event_data, 32'h0);

        // Two events queued, then an asynchronous reset between clock edges.
        smp3_event(32'h4000_0000, 32'h4000_4000);
        smp3_event(32'h8000_0000, 32'h8000_C000);
        check_count("pre_reset_count", 2);
        check("pre_reset_buttons", 32'(bus.buttons), 32'h8000);
        PRESERN = 1'b0;
        #2;
        check("async_valid", 32'(bus.event_valid), 32'h0);
        check_count("async_count", 0);
        check("async_buttons", 32'(bus.buttons), 32'h0);
        check("async_overflow", 32'(bus.overflow), 32'h0);
        check("async_data", bus.event_data, 32'h0);
        exp_q.delete();
        @(negedge PCLK);
        PRESERN = 1'b1;
        @(posedge PCLK);
        #1;

        // A pressed: needs three samples, a fourth identical one adds nothing.
        smp(32'h8000_0000);
        check_count("a_s1_count", 0);
        smp(32'h8000_0000);
        check_count("a_s2_count", 0);
        exp_q.push_back(32'h8000_8000);
        smp(32'h8000_0000);
        check("a_buttons", 32'(bus.buttons), 32'h8000);
        check("a_head", bus.event_data, 32'h8000_8000);
        check_count("a_s3_count", 1);
        smp(32'h8000_0000);
        check_count("a_s4_count", 1);
        pop_one();
        check_count("a_pop_count", 0);

        smp3_event(32'h0000_0000, 32'h0000_8000);
        pop_one();

        // Glitch restarts the run.
        smp(32'h4000_0000);
        smp(32'h4000_0000);
        smp(32'h0000_0000);
        smp(32'h4000_0000);
        smp(32'h4000_0000);
        check_count("glitch_count", 0);
        check("glitch_buttons", 32'(bus.buttons), 32'h0);
        exp_q.push_back(32'h4000_4000);
        smp(32'h4000_0000);
        smp(32'h4000_0000);
        check_count("glitch_evt_count", 1);
        check("glitch_head", bus.event_data, 32'h4000_4000);
        pop_one();

        // Deadzone on both axes.
        smp(32'h4000_08F8);
        check("dz_x_08", 32'(bus.stick_x), 32'h00);
        check("dz_y_f8", 32'(bus.stick_y), 32'h00);
        smp(32'h4000_F780);
        check("dz_x_f7", 32'(bus.stick_x), 32'hF7);
        check("dz_y_80", 32'(bus.stick_y), 32'h80);
        smp(32'h4000_0907);
        check("dz_x_09", 32'(bus.stick_x), 32'h09);
        check("dz_y_07", 32'(bus.stick_y), 32'h00);
        smp(32'h4000_8009);
        check("dz_x_80", 32'(bus.stick_x), 32'h80);
        check("dz_y_09", 32'(bus.stick_y), 32'h09);
        check_count("dz_count", 0);

        // Fill, drop, clear, push+pop while full, set-beats-clear.
        smp3_event(32'h0001_0000, 32'h0001_4001);
        smp3_event(32'h0003_0000, 32'h0003_0002);
        smp3_event(32'h0007_0000, 32'h0007_0004);
        smp3_event(32'h000F_0000, 32'h000F_0008);
        check_count("full_count", 4);
        check("full_overflow", 32'(bus.overflow), 32'h0);
        repeat (3) smp(32'h001F_0000);
        check_count("drop_count", 4);
        check("drop_overflow", 32'(bus.overflow), 32'h1);
        check("drop_head", bus.event_data, 32'h0001_4001);
        check("drop_buttons", 32'(bus.buttons), 32'h001F);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        check("clear_overflow", 32'(bus.overflow), 32'h0);
        smp(32'h003F_0000);
        smp(32'h003F_0000);
        exp_q.push_back(32'h003F_0020);
        cycle(1'b1, 1'b1, 32'h003F_0000, 1'b1, 1'b0);
        check_count("fullpp_count", 4);
        check("fullpp_overflow", 32'(bus.overflow), 32'h0);
        check("fullpp_head", bus.event_data, 32'h0003_0002);
        smp(32'h007F_0000);
        smp(32'h007F_0000);
        cycle(1'b1, 1'b1, 32'h007F_0000, 1'b0, 1'b1);
        check("setwins_overflow", 32'(bus.overflow), 32'h1);
        check_count("setwins_count", 4);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        check("clear2_overflow", 32'(bus.overflow), 32'h0);
        repeat (4) pop_one();
        check_count("drain_count", 0);
        check("drain_valid", 32'(bus.event_valid), 32'h0);
        check("drain_data", bus.event_data, 32'h0);

        // Empty-FIFO pop, and push+pop on empty.
        pop_one();
        check_count("empty_pop_count", 0);
        smp(32'h00FF_0000);
        smp(32'h00FF_0000);
        exp_q.push_back(32'h00FF_0080);
        cycle(1'b1, 1'b1, 32'h00FF_0000, 1'b1, 1'b0);
        check_count("emptypp_count", 1);
        check("emptypp_head", bus.event_data, 32'h00FF_0080);
        pop_one();
        check_count("emptypp_pop_count", 0);

        // Disabled: samples ignored, pop still works.
        repeat (3) cycle(1'b0, 1'b1, 32'h1234_7F7F, 1'b0, 1'b0);
        check_count("dis_count", 0);
        check("dis_buttons", 32'(bus.buttons), 32'h00FF);
        check("dis_stick_x", 32'(bus.stick_x), 32'h00);
        check("dis_stick_y", 32'(bus.stick_y), 32'h00);
        smp3_event(32'h0000_0000, 32'h0000_00FF);
        check_count("dis_pre_pop_count", 1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check_count("dis_pop_count", 0);

        check("scoreboard_left", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
